// File: rtl/delete_event_queue.sv
// First-word-fall-through queue of Delete Order references feeding the order-book consumer.
// Optional saturating statistics counters are enabled with `define DELETE_QUEUE_STATS_EN.
module delete_event_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              delete_internal_valid,
  input  logic              delete_packet_invalid,
  input  logic [63:0]       delete_order_ref,
  input  logic [3:0]        delete_parsed_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_order_ref,
  output logic [PTR_W:0]    fifo_count,
  output logic              fifo_full,
  output logic              overflow_pulse,
  output logic              type_error_pulse,
  output logic [15:0]       accepted_count,
  output logic [15:0]       dropped_count,
  output logic [15:0]       invalid_count
);

  localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [3:0]       TYPE_DELETE = 4'd2;

  // Asynchronous read keeps the head visible right after the accepting edge.
  logic [63:0]      mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             overflow_reg;
  logic             type_error_reg;

  logic push_cand;
  logic type_error;
  logic full;
  logic not_empty;
  logic pop;
  logic accept;
  logic drop;

  assign full       = (count_reg == FULL_COUNT);
  assign not_empty  = (count_reg != '0);
  assign push_cand  = delete_internal_valid && (delete_parsed_type == TYPE_DELETE);
  assign type_error = delete_internal_valid && (delete_parsed_type != TYPE_DELETE);
  assign pop        = not_empty && out_ready;
  // When full, a same-cycle pop frees the slot the write pointer already addresses.
  assign accept     = push_cand && (!full || pop);
  assign drop       = push_cand && full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_reg[wr_ptr_reg] <= delete_order_ref;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      type_error_reg <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg      <= count_next;
      overflow_reg   <= drop;
      type_error_reg <= type_error;
    end
  end

  assign out_valid        = not_empty;
  assign out_order_ref    = not_empty ? mem_reg[rd_ptr_reg] : 64'h0;
  assign fifo_count       = count_reg;
  assign fifo_full        = full;
  assign overflow_pulse   = overflow_reg;
  assign type_error_pulse = type_error_reg;

`ifdef DELETE_QUEUE_STATS_EN
  logic [15:0] accepted_reg;
  logic [15:0] dropped_reg;
  logic [15:0] invalid_reg;
  logic [1:0]  invalid_inc;
  logic [16:0] invalid_sum;

  // A type error and a packet-invalid pulse may land in the same cycle.
  assign invalid_inc = {1'b0, type_error} + {1'b0, delete_packet_invalid};
  assign invalid_sum = {1'b0, invalid_reg} + {15'd0, invalid_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_reg <= '0;
      dropped_reg  <= '0;
      invalid_reg  <= '0;
    end else begin
      if (accept && (accepted_reg != 16'hFFFF)) begin
        accepted_reg <= accepted_reg + 16'd1;
      end
      if (drop && (dropped_reg != 16'hFFFF)) begin
        dropped_reg <= dropped_reg + 16'd1;
      end
      invalid_reg <= invalid_sum[16] ? 16'hFFFF : invalid_sum[15:0];
    end
  end

  assign accepted_count = accepted_reg;
  assign dropped_count  = dropped_reg;
  assign invalid_count  = invalid_reg;
`else
  logic unused_packet_invalid;
  assign unused_packet_invalid = delete_packet_invalid;

  assign accepted_count = '0;
  assign dropped_count  = '0;
  assign invalid_count  = '0;
`endif

endmodule

// File: tb/tb_delete_event_queue.sv
// Bench for delete_event_queue: directed scenarios plus a randomized run, all checked
// against a queue-based reference model.
module tb_delete_event_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              delete_internal_valid;
  logic              delete_packet_invalid;
  logic [63:0]       delete_order_ref;
  logic [3:0]        delete_parsed_type;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_order_ref;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_full;
  logic              overflow_pulse;
  logic              type_error_pulse;
  logic [15:0]       accepted_count;
  logic [15:0]       dropped_count;
  logic [15:0]       invalid_count;

  always #5 clk = ~clk;

  delete_event_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .delete_internal_valid (delete_internal_valid),
    .delete_packet_invalid (delete_packet_invalid),
    .delete_order_ref      (delete_order_ref),
    .delete_parsed_type    (delete_parsed_type),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_order_ref         (out_order_ref),
    .fifo_count            (fifo_count),
    .fifo_full             (fifo_full),
    .overflow_pulse        (overflow_pulse),
    .type_error_pulse      (type_error_pulse),
    .accepted_count        (accepted_count),
    .dropped_count         (dropped_count),
    .invalid_count         (invalid_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue, counters as plain integers.
  logic [63:0] q[$];
  logic [63:0] acc_log[$];
  logic [63:0] pop_log[$];
  bit          logging = 0;
  int          m_acc   = 0;
  int          m_drop  = 0;
  int          m_inv   = 0;
  bit          m_ovf   = 0;
  bit          m_terr  = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_order_ref", out_order_ref, (q.size() != 0) ? q[0] : 64'h0);
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("fifo_full", 64'(fifo_full), 64'(q.size() == DEPTH));
    chk("overflow_pulse", 64'(overflow_pulse), 64'(m_ovf));
    chk("type_error_pulse", 64'(type_error_pulse), 64'(m_terr));
`ifdef DELETE_QUEUE_STATS_EN
    chk("accepted_count", 64'(accepted_count), 64'(m_acc));
    chk("dropped_count", 64'(dropped_count), 64'(m_drop));
    chk("invalid_count", 64'(invalid_count), 64'(m_inv));
`else
    chk("accepted_count", 64'(accepted_count), 64'h0);
    chk("dropped_count", 64'(dropped_count), 64'h0);
    chk("invalid_count", 64'(invalid_count), 64'h0);
`endif
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, check #1 later.
  task automatic step(input bit v, input logic [3:0] t, input logic [63:0] r,
                      input bit rdy, input bit pinv, input bit rs);
    bit pop;
    bit cand;
    delete_internal_valid = v;
    delete_parsed_type    = t;
    delete_order_ref      = r;
    out_ready             = rdy;
    delete_packet_invalid = pinv;
    rst                   = rs;
    pop = !rs && (q.size() != 0) && rdy;
    if (pop && logging) pop_log.push_back(out_order_ref);
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_acc  = 0;
      m_drop = 0;
      m_inv  = 0;
      m_ovf  = 0;
      m_terr = 0;
    end else begin
      cand   = v && (t == 4'd2);
      m_terr = v && (t != 4'd2);
      m_ovf  = cand && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (cand && !m_ovf) begin
        q.push_back(r);
        m_acc = sat16(m_acc + 1);
        if (logging) acc_log.push_back(r);
      end
      if (m_ovf) m_drop = sat16(m_drop + 1);
      m_inv = sat16(m_inv + int'(m_terr) + int'(pinv));
    end
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 4'd0, 64'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    delete_internal_valid = 1'b0;
    delete_packet_invalid = 1'b0;
    delete_order_ref      = 64'h0;
    delete_parsed_type    = 4'd0;
    out_ready             = 1'b0;
    rst                   = 1'b1;

    // Reset state
    do_reset();
    do_reset();
    chk("reset_count", 64'(fifo_count), 64'h0);

    // Single push, no consumer
    step(1'b1, 4'd2, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0);
    chk("single_ref", out_order_ref, 64'h0123_4567_89AB_CDEF);
    chk("single_count", 64'(fifo_count), 64'd1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill to full, overflow, drain 1..8
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 4'd2, 64'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 64'(fifo_full), 64'd1);
    step(1'b1, 4'd2, 64'd9, 1'b0, 1'b0, 1'b0);
    chk("ovf_pulse", 64'(overflow_pulse), 64'd1);
    idle(1'b0);
    chk("ovf_pulse_end", 64'(overflow_pulse), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_ref", out_order_ref, 64'(i));
      idle(1'b1);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 4'd2, 64'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 64'd9, 1'b1, 1'b0, 1'b0);
    chk("swap_count", 64'(fifo_count), 64'd8);
    for (int i = 2; i <= 9; i++) begin
      chk("swap_drain_ref", out_order_ref, 64'(i));
      idle(1'b1);
    end

    // Wrong type and packet-invalid pulses
    step(1'b1, 4'd2, 64'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd5, 64'hBB, 1'b0, 1'b0, 1'b0);
    chk("terr_pulse", 64'(type_error_pulse), 64'd1);
    chk("terr_count", 64'(fifo_count), 64'd1);
    idle(1'b0);
    step(1'b0, 4'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd3, 64'hCC, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // Reset wins over a simultaneous push
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 4'd2, 64'(16 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 64'h55, 1'b1, 1'b0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ref", out_order_ref, 64'h0);

    // Random pushes with random back-pressure across pointer wrap
    logging = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'd2, {$urandom, $urandom}, 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'b0);
      if ($urandom_range(2) == 0) idle(1'($urandom_range(1)));
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
    logging = 0;
    chk("rand_drained", 64'(out_valid), 64'd0);
    chk("rand_len", 64'(pop_log.size()), 64'(acc_log.size()));
    for (int i = 0; i < acc_log.size(); i++) begin
      chk("rand_seq", (i < pop_log.size()) ? pop_log[i] : 64'hX, acc_log[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delete_event_queue.md
DELETE_EVENT_QUEUE -- requirements
Module: delete_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, at least 2.
REQ-002 SHALL have parameter PTR_W, default 3, pointer width equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port delete_internal_valid, input, 1 bit: one-cycle pulse from the Delete Order decoder.
REQ-006 SHALL have port delete_packet_invalid, input, 1 bit: malformed/truncated 'D' message pulse from the decoder.
REQ-007 SHALL have port delete_order_ref, input, 64 bits: parsed order reference, valid with delete_internal_valid.
REQ-008 SHALL have port delete_parsed_type, input, 4 bits: parsed type code; 4'd2 denotes Delete.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry available to the order-book consumer.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-011 SHALL have port out_order_ref, output, 64 bits: head entry order reference.
REQ-012 SHALL have port fifo_count, output, PTR_W+1 bits: current occupancy.
REQ-013 SHALL have port fifo_full, output, 1 bit: fifo_count == DEPTH.
REQ-014 SHALL have port overflow_pulse, output, 1 bit: one-cycle pulse when an event is dropped.
REQ-015 SHALL have port type_error_pulse, output, 1 bit: one-cycle pulse when a valid arrives with a wrong type.
REQ-016 SHALL have ports accepted_count, dropped_count and invalid_count, output, 16 bits each: statistics counters.

Function
REQ-017 SHALL form a push candidate when delete_internal_valid=1 and delete_parsed_type=4'd2.
REQ-018 SHALL, when delete_internal_valid=1 and delete_parsed_type≠4'd2, discard the event and assert type_error_pulse on the next cycle.
REQ-019 SHALL define a pop as out_valid && out_ready; out_ready SHALL be ignored while out_valid=0.
REQ-020 SHALL accept a push candidate when not full, or when full and a pop occurs in the same cycle.
REQ-021 SHALL, on simultaneous push and pop when full, leave fifo_count unchanged and overwrite the freed slot.
REQ-022 SHALL drop a push candidate that arrives while full with no pop, leave contents unchanged, and assert overflow_pulse on the next cycle.
REQ-023 SHALL be first-word-fall-through: an entry accepted at edge N drives out_valid=1 after edge N; there is no same-cycle bypass when empty.
REQ-024 SHALL drive out_valid = (fifo_count≠0), and out_order_ref = head entry, or 64'h0 when empty.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow below 0.
REQ-026 SHALL preserve FIFO order: entries leave in arrival order with no loss or duplication.
REQ-027 SHALL register overflow_pulse and type_error_pulse, each high for exactly one cycle per event.
REQ-028 SHALL treat delete_packet_invalid as statistics-only; it SHALL have no effect on FIFO contents.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear pointers, fifo_count, out_valid, fifo_full, both pulses and all counters to 0; storage contents need not be reset.
REQ-030 SHALL give rst priority over a simultaneous push or pop; queued entries are discarded and out_valid=0 after that edge.

Configuration
REQ-031 SHALL, with DELETE_QUEUE_STATS_EN defined, make accepted_count count accepted pushes, dropped_count count overflow drops, and invalid_count count delete_packet_invalid pulses plus type errors, each saturating at 16'hFFFF.
REQ-032 SHALL, without DELETE_QUEUE_STATS_EN, keep the three counter ports but tie them to 0 and synthesize no counter logic; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover: reset, then one push of ref 64'h0123_4567_89AB_CDEF type 2 with out_ready=0 -> out_valid=1 next cycle, out_order_ref=64'h0123_4567_89AB_CDEF, fifo_count=1.
REQ-034 SHALL cover: 8 pushes of refs 1..8, then a 9th push of ref 9 with out_ready=0 -> fifo_full=1, overflow_pulse for one cycle, drain yields 1..8, dropped_count=1 (STATS_EN).
REQ-035 SHALL cover: full queue, push ref 9 together with out_ready=1 -> ref 1 popped, fifo_count stays 8, later drain yields 2..9.
REQ-036 SHALL cover: valid with delete_parsed_type=4'd5 -> type_error_pulse for one cycle, fifo_count unchanged, invalid_count=1 (STATS_EN) or 0 (no STATS_EN).
REQ-037 SHALL cover: 3 entries queued, rst asserted together with a push -> next cycle out_valid=0, fifo_count=0, out_order_ref=64'h0.
REQ-038 SHALL cover: 20 random pushes with random out_ready across pointer wrap -> output sequence matches the accepted input sequence.
